// File: rtl/mem_test_pkg.sv
// Shared types and pattern helpers for the on-chip RAM tester.
// Pattern lanes are seed-relative word counters, optionally inverted.
package mem_test_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 512;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int LANES      = DATA_W_DEF / 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    function automatic logic [31:0] pattern_lane(
        input logic [31:0] seed,
        input logic [31:0] addr,
        input int          lanes,
        input int          idx,
        input logic        inv
    );
        logic [31:0] v;
        v = seed + addr * 32'(lanes) + 32'(idx);
        return inv ? ~v : v;
    endfunction

    function automatic logic [DATA_W_DEF-1:0] pattern_word(
        input logic [31:0] seed,
        input logic [31:0] addr,
        input logic        inv
    );
        logic [DATA_W_DEF-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*32 +: 32] = pattern_lane(seed, addr, LANES, i, inv);
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_test_expect_pipe.sv
// Delay line carrying {valid, addr, pass} of each read so the
// expected word can be rebuilt when the RAM returns its data.
module mem_test_expect_pipe #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_pass,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_pass
);

    logic [LAT-1:0]    v;
    logic [LAT-1:0]    p;
    logic [ADDR_W-1:0] a [LAT];

    // shift read tags one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            p <= '0;
            for (int i = 0; i < LAT; i++) begin
                a[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            p[0] <= in_pass;
            a[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                p[i] <= p[i-1];
                a[i] <= a[i-1];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_pass  = p[LAT-1];
    assign out_addr  = a[LAT-1];

endmodule

// File: rtl/onchip_mem_tester.sv
// Two-pass write/read/compare tester for one on-chip RAM port.
// Bus outputs are registered from next-state values.
module onchip_mem_tester
    import mem_test_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 512,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic [31:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                first_err_pass,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_clken,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata
);

    localparam int LANES_L = DATA_W / 32;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(READ_LATENCY - 1);

    function automatic logic [DATA_W-1:0] make_word(
        input logic [31:0]       s,
        input logic [ADDR_W-1:0] a,
        input logic              inv
    );
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES_L; i++) begin
            w[i*32 +: 32] = pattern_lane(s, 32'(a), LANES_L, i, inv);
        end
        return w;
    endfunction

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              pass_idx, pass_idx_n;
    logic [2:0]        drain, drain_n;
    logic [31:0]       seed_q, seed_n;
    logic              accept;
    logic              have_err;
    logic              pv, pp;
    logic [ADDR_W-1:0] pa;
    logic              mismatch;
    logic [ADDR_W+1:0] err_n;

    assign accept = (state == IDLE) && start;
    assign seed_n = accept ? seed : seed_q;

    // next-state sequencing of write, read and drain phases
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        pass_idx_n = pass_idx;
        drain_n    = drain;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = WRITE;
                    addr_n     = '0;
                    pass_idx_n = 1'b0;
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    state_n = READ;
                    addr_n  = '0;
                end else begin
                    addr_n = addr + 1'b1;
                end
            end
            READ: begin
                if (addr == LAST_ADDR) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                    drain_n = '0;
                end else begin
                    addr_n = addr + 1'b1;
                end
            end
            DRAIN: begin
                if (drain == LAST_DRAIN) begin
                    if (pass_idx) begin
                        state_n = FINISH;
                    end else begin
                        state_n    = WRITE;
                        pass_idx_n = 1'b1;
                    end
                end else begin
                    drain_n = drain + 1'b1;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // sequencer state
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            addr     <= '0;
            pass_idx <= 1'b0;
            drain    <= '0;
            seed_q   <= '0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            pass_idx <= pass_idx_n;
            drain    <= drain_n;
            seed_q   <= seed_n;
        end
    end

    // registered bus command and status strobes
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            avm_chipselect <= (state_n == WRITE) || (state_n == READ);
            avm_write      <= (state_n == WRITE);
            avm_address    <= addr_n;
            avm_writedata  <= (state_n == WRITE) ?
                              make_word(seed_n, addr_n, pass_idx_n) : '0;
            avm_byteenable <= {(DATA_W/8){(state_n == WRITE) ||
                                          (state_n == READ)}};
            busy           <= (state_n != IDLE);
            done           <= (state_n == FINISH);
        end
    end

    assign avm_clken = busy;

    mem_test_expect_pipe #(
        .LAT    (READ_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .in_valid  (state == READ),
        .in_addr   (addr),
        .in_pass   (pass_idx),
        .out_valid (pv),
        .out_addr  (pa),
        .out_pass  (pp)
    );

    assign mismatch = pv && (avm_readdata != make_word(seed_q, pa, pp));
    assign err_n    = accept ? '0 :
                      error_count + {{(ADDR_W+1){1'b0}}, mismatch};

    // error accounting and final verdict
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            error_count    <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
            have_err       <= 1'b0;
            pass           <= 1'b0;
        end else begin
            error_count <= err_n;
            if (accept) begin
                first_err_addr <= '0;
                first_err_pass <= 1'b0;
                have_err       <= 1'b0;
                pass           <= 1'b0;
            end else begin
                if (mismatch && !have_err) begin
                    first_err_addr <= pa;
                    first_err_pass <= pp;
                    have_err       <= 1'b1;
                end
                if (state_n == FINISH) begin
                    pass <= (err_n == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_tester.sv
// Bench for onchip_mem_tester: RAM models with fault injection and
// a pass/address reference model of expected error results.
module tb_onchip_mem_tester;

    localparam int AW = 6;
    localparam int DW = 512;
    localparam int BW = DW / 8;
    localparam int D  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          st0, busy0, done0, pass0, fp0, ck0, cs0, wr0;
    logic [31:0]   sd0;
    logic [AW+1:0] ec0;
    logic [AW-1:0] fa0, ad0;
    logic [DW-1:0] wd0, rd0;
    logic [BW-1:0] be0;

    logic          st1, busy1, done1, pass1, fp1, ck1, cs1, wr1;
    logic [31:0]   sd1;
    logic [AW+1:0] ec1;
    logic [AW-1:0] fa1, ad1;
    logic [DW-1:0] wd1, rd1;
    logic [BW-1:0] be1;

    logic zero_all, stuck_en, stuck_val;
    int   stuck_addr, stuck_bit;

    int tests = 0;
    int fails = 0;

    onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(st0), .seed(sd0),
        .busy(busy0), .done(done0), .pass(pass0), .error_count(ec0),
        .first_err_addr(fa0), .first_err_pass(fp0), .avm_address(ad0),
        .avm_clken(ck0), .avm_chipselect(cs0), .avm_write(wr0),
        .avm_writedata(wd0), .avm_byteenable(be0), .avm_readdata(rd0)
    );

    onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(st1), .seed(sd1),
        .busy(busy1), .done(done1), .pass(pass1), .error_count(ec1),
        .first_err_addr(fa1), .first_err_pass(fp1), .avm_address(ad1),
        .avm_clken(ck1), .avm_chipselect(cs1), .avm_write(wr1),
        .avm_writedata(wd1), .avm_byteenable(be1), .avm_readdata(rd1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] w,
                                              input int a);
        logic [DW-1:0] r;
        r = zero_all ? '0 : w;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    logic [DW-1:0] mem0 [D];
    logic [DW-1:0] mem1 [D];
    logic [DW-1:0] rp1  [3];

    always @(posedge clk) begin
        if (cs0) begin
            if (wr0) mem0[ad0] <= wd0;
            else rd0 <= corrupt(mem0[ad0], int'(ad0));
        end
    end

    always @(posedge clk) begin
        rp1[0] <= (cs1 && !wr1) ? corrupt(mem1[ad1], int'(ad1)) : '0;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
        if (cs1 && wr1) mem1[ad1] <= wd1;
    end
    assign rd1 = rp1[2];

    function automatic logic [DW-1:0] pat(input logic [31:0] s,
                                          input int a, input int p);
        logic [DW-1:0] w;
        logic [31:0] lane;
        for (int i = 0; i < DW / 32; i++) begin
            lane = s + 32'(a * (DW / 32) + i);
            w[i*32 +: 32] = (p != 0) ? ~lane : lane;
        end
        return w;
    endfunction

    task automatic model(input logic [31:0] s, output int cnt,
                         output int fa, output int fp);
        logic [DW-1:0] w;
        cnt = 0; fa = 0; fp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < D; a++) begin
                w = pat(s, a, p);
                if (corrupt(w, a) != w) begin
                    if (cnt == 0) begin
                        fa = a;
                        fp = p;
                    end
                    cnt++;
                end
            end
        end
    endtask

    task automatic run0(input logic [31:0] s, input int restart_at,
                        input int reset_at, output int done_cyc);
        int nw, nr, bad_be;
        nw = 0; nr = 0; bad_be = 0;
        @(negedge clk);
        sd0 = s;
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        sd0 = $urandom;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("c1_write", 64'(wr0), 64'd1);
                chk("c1_addr", 64'(ad0), 64'd0);
                chk("c1_lane0", 64'(wd0[31:0]), 64'(s));
                chk("c1_busy", 64'(busy0), 64'd1);
            end
            if (cs0) begin
                if (be0 != '1) bad_be++;
                if (wr0) nw++;
                else nr++;
            end
            if (c == restart_at) begin
                st0 = 1'b1;
                sd0 = $urandom;
            end else begin
                st0 = 1'b0;
            end
            if (c == reset_at) begin
                rst_n = 1'b0;
                done_cyc = 0;
                break;
            end
            if (done0) begin
                done_cyc = c;
                break;
            end
        end
        st0 = 1'b0;
        chk("byteenable", 64'(bad_be), 64'd0);
        if (reset_at < 0) begin
            chk("n_writes", 64'(nw), 64'd128);
            chk("n_reads", 64'(nr), 64'd128);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] s,
                                input int dc);
        int cnt, fa, fp;
        model(s, cnt, fa, fp);
        chk({tag, "_done_cyc"}, 64'(dc), 64'd259);
        chk({tag, "_err_cnt"}, 64'(ec0), 64'(cnt));
        chk({tag, "_pass"}, 64'(pass0), 64'(cnt == 0));
        chk({tag, "_ferr_addr"}, 64'(fa0), 64'(fa));
        chk({tag, "_ferr_pass"}, 64'(fp0), 64'(fp));
        @(negedge clk);
        chk({tag, "_done_low"}, 64'(done0), 64'd0);
        chk({tag, "_busy_low"}, 64'(busy0), 64'd0);
        chk({tag, "_pass_hold"}, 64'(pass0), 64'(cnt == 0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, 64'(busy0), 64'd0);
        chk({tag, "_done"}, 64'(done0), 64'd0);
        chk({tag, "_pass"}, 64'(pass0), 64'd0);
        chk({tag, "_errs"}, 64'(ec0), 64'd0);
        chk({tag, "_ferr"}, 64'({fa0, fp0}), 64'd0);
        chk({tag, "_bus"}, 64'({cs0, wr0, ck0, ad0}), 64'd0);
        chk({tag, "_wdata"}, 64'(|wd0), 64'd0);
    endtask

    initial begin
        int dc;
        logic [31:0] s;
        rst_n = 1'b0;
        st0 = 1'b0; sd0 = '0;
        st1 = 1'b0; sd1 = '0;
        zero_all = 1'b0; stuck_en = 1'b0; stuck_val = 1'b0;
        stuck_addr = 0; stuck_bit = 0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        run0(32'd0, -1, -1, dc);
        check_result("ideal_s0", 32'd0, dc);

        stuck_en = 1'b1; stuck_addr = 5; stuck_bit = 7; stuck_val = 1'b0;
        run0(32'd0, -1, -1, dc);
        check_result("bit7_w5", 32'd0, dc);
        chk("bit7_w5_cnt1", 64'(ec0), 64'd1);
        chk("bit7_w5_fp1", 64'(fp0), 64'd1);
        stuck_en = 1'b0;

        s = $urandom;
        run0(s, 100, -1, dc);
        check_result("restart_ign", s, dc);

        s = $urandom;
        run0(s, -1, 150, dc);
        #1;
        chk_reset_outs("rst_mid");
        repeat (2) @(negedge clk);
        chk("rst_mid_nodone", 64'(done0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        s = $urandom;
        run0(s, -1, -1, dc);
        check_result("after_rst", s, dc);

        zero_all = 1'b1;
        run0(32'd1, -1, -1, dc);
        check_result("zeros", 32'd1, dc);
        chk("zeros_cnt128", 64'(ec0), 64'd128);
        zero_all = 1'b0;

        repeat (4) begin
            s = $urandom;
            stuck_en = 1'b1;
            stuck_addr = $urandom_range(0, D - 1);
            stuck_bit = $urandom_range(0, DW - 1);
            stuck_val = 1'($urandom_range(0, 1));
            run0(s, -1, -1, dc);
            check_result("rand_stuck", s, dc);
        end
        stuck_en = 1'b0;

        @(negedge clk);
        sd1 = 32'hFFFF_FFF0;
        st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        dc = -1;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (c == 1) chk("k3_c1_lane15", 64'(wd1[15*32 +: 32]),
                            64'hFFFF_FFFF);
            if (c == 2) chk("k3_c2_lane0", 64'(wd1[31:0]), 64'd0);
            if (done1) begin
                dc = c;
                break;
            end
        end
        chk("k3_done_cyc", 64'(dc), 64'd263);
        chk("k3_pass", 64'(pass1), 64'd1);
        chk("k3_errs", 64'(ec1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onchip_mem_tester.md
# onchip_mem_tester

Avalon-MM initiator that exercises one slave port of the dual-port on-chip RAM in the memory test project (64 words × 512 bits). On `start` it runs two passes. Each pass writes an address-derived pattern to every word, reads every word back, and checks the returned data against the pattern. Pass 0 uses the true pattern and pass 1 its bitwise complement. One tester instance connects to each RAM port, s1 and s2.

## Interface
Parameters:
- `ADDR_W`, default 6: word address width; depth is `DEPTH = 2**ADDR_W`.
- `DATA_W`, default 512: data width; must be a multiple of 32.
- `READ_LATENCY`, default 1: cycles from read command to valid `readdata`; legal range 1..4.

Ports (name, direction, width, meaning):
- `clk_clk`, in, 1: single clock.
- `reset_reset_n`, in, 1: reset, asynchronous assert, active low.
- `start`, in, 1: one-cycle request to begin a test; ignored unless in IDLE.
- `seed`, in, 32: pattern seed; sampled on accepted `start`.
- `busy`, out, 1: high from the cycle after `start` until `done`.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: result; valid from `done` until the next accepted `start`.
- `error_count`, out, ADDR_W+2: total word mismatches over both passes.
- `first_err_addr`, out, ADDR_W: address of the first mismatch.
- `first_err_pass`, out, 1: pass index (0 or 1) of the first mismatch.
- `avm_address`, out, ADDR_W: word address.
- `avm_clken`, out, 1: equals `busy`.
- `avm_chipselect`, out, 1: high on a command cycle.
- `avm_write`, out, 1: 1 = write, 0 = read.
- `avm_writedata`, out, DATA_W: write data.
- `avm_byteenable`, out, DATA_W/8: all ones whenever `avm_chipselect` is high.
- `avm_readdata`, in, DATA_W: read data from the RAM.

## Operation
- Pattern: 32-bit lane i of word a is `P(a,i) = seed + a*(DATA_W/32) + i`, taken mod 2^32. Pass 1 writes and expects `~P`.
- FSM states and transitions:
  - IDLE → WRITE on `start`.
  - WRITE issues DEPTH writes, one per cycle, at addresses 0..DEPTH-1, then → READ.
  - READ issues DEPTH reads at addresses 0..DEPTH-1, then → DRAIN.
  - DRAIN waits READ_LATENCY cycles, then → WRITE with pass = 1, or → FINISH after pass 1.
  - FINISH pulses `done` and returns → IDLE.
- Compare: each read's address and pass index travel down a READ_LATENCY-deep pipe. When the pipe output is valid, the full `avm_readdata` word is compared against the regenerated expected word.
  - A mismatch increments `error_count` by 1 per word.
  - The first mismatch after `start` latches `first_err_addr` and `first_err_pass`.
- `pass` = (`error_count` == 0), registered in FINISH.
- Accepted `start` clears `error_count`, `first_err_*` and `pass`.
- `start` while busy is ignored, with no effect on the running test.
- Address wrap: the address counter runs 0..DEPTH-1 and resets to 0 at each phase change. It never wraps inside a phase.
- Reset mid-test:
  - All state is abandoned immediately and the FSM goes to IDLE.
  - Partial RAM contents are not restored.
  - No `done` is issued.

## Timing
- Reset values:
  - `busy`, `done`, `pass`, `error_count`, `first_err_addr`, `first_err_pass` = 0.
  - `avm_chipselect`, `avm_write`, `avm_clken` = 0.
  - `avm_address` = 0 and `avm_writedata` = 0.
- All `avm_*` outputs are registered. With `start` sampled at edge 0, cycle numbering is (k = READ_LATENCY):
  - Pass 0 writes: cycles 1..DEPTH.
  - Pass 0 reads: cycles DEPTH+1..2·DEPTH.
  - Pass 0 drain: cycles 2·DEPTH+1..2·DEPTH+k.
  - Pass 1 repeats the same sequence offset by 2·DEPTH+k.
  - `done` is high in cycle 4·DEPTH+2k+1.
- For DEPTH = 64 and k = 1, `done` is in cycle 259.
- Read issued in cycle t: `avm_readdata` is compared in cycle t+k, and `error_count` updates in cycle t+k+1.
- No wait states exist: the on-chip RAM has no waitrequest, so every command cycle completes.

## Structure
- `mem_test_pkg` holds:
  - the FSM state enum (IDLE, WRITE, READ, DRAIN, FINISH);
  - the `pattern_word(seed, addr, inv)` function;
  - the constants `DEPTH` and `LANES = DATA_W/32`.
- One sub-module, `mem_test_expect_pipe`, is a READ_LATENCY-deep shift register of {valid, addr, pass}.

## Test plan
- Ideal RAM model, k = 1, seed = 0:
  - `done` in cycle 259, `pass` = 1, `error_count` = 0.
  - Cycle 1 drives `avm_write` = 1, `avm_address` = 0, lane 0 = 0x00000000.
- Model forces bit 7 of word 5 lane 0 to 0 on read, seed = 0:
  - `pass` = 0, `error_count` = 1, `first_err_addr` = 5, `first_err_pass` = 1.
- k = 3 ideal model, seed = 0xFFFFFFF0: lanes wrap mod 2^32, `pass` = 1, `done` in cycle 263.
- Pulse `start` again in cycle 100 of a running test: no restart, and `done` still occurs in cycle 259.
- Assert `reset_reset_n` low in cycle 150, then release it and pulse `start`:
  - all outputs return to their reset values;
  - the next test completes normally with `pass` = 1.
- Model returns all zeros on every read: `error_count` = 128, `first_err_addr` = 0, `first_err_pass` = 0 (seed = 1).
